subtractor: RTL and testbench
=============================

# subtractor

Parameterized N-bit ripple-borrow subtractor with a registered output stage. It computes D = A − B − B_in and produces a borrow-out plus status flags. Outputs are captured on the clock edge for direct use in a synchronous datapath. It is a leaf arithmetic block, built as a chain of one-bit full-subtractor cells.

## Interface
- N, default 4: operand and result width in bits; legal range is N ≥ 1.
- clk  in  1  single clock; rising-edge active.
- rst_n  in  1  reset; asynchronous, active-low.
- A  in  N  minuend, unsigned.
- B  in  N  subtrahend, unsigned.
- B_in  in  1  borrow-in.
- in_valid  in  1  when high, the current A/B/B_in are captured at the next rising edge.
- D  out  N  difference, registered.
- B_out  out  1  borrow-out, registered.
- V  out  1  two's-complement overflow of A − B − B_in, registered.
- Z  out  1  high when the registered D is zero.
- out_valid  out  1  high for one cycle after each capture.

## Operation
- Core is combinational ripple-borrow. Bit i is d_i = a_i ^ b_i ^ bor_i.
- Borrow into bit i+1 is bor_{i+1} = (~a_i & b_i) | (~(a_i ^ b_i) & bor_i).
- Chain seed: bor_0 = B_in. B_out is bor_N.
- D is (A − B − B_in) mod 2^N.
- B_out is 1 exactly when A < B + B_in (unsigned compare at N+1 bits).
- V = (A[N-1] ^ B[N-1]) & (A[N-1] ^ D[N-1]), evaluated on the combinational difference before the register.
- Z = (D == 0), evaluated on the combinational difference and registered with it.
- A, B and B_in equal to all-ones are legal; no saturation and no error condition.

## Timing
- Latency is 1 cycle: operands present with in_valid=1 at edge k give D, B_out, V, Z valid after edge k.
- out_valid=1 during the cycle following edge k.
- in_valid=0 at an edge: D, B_out, V and Z hold their previous values; out_valid goes 0.
- Back-to-back in_valid=1 gives one result per cycle; there is no backpressure.
- Reset (rst_n=0, asynchronous, immediate) forces D=0, B_out=0, V=0, Z=0, out_valid=0, with no clock required.
- Reset asserted mid-stream discards any in-flight capture.
- First capture after reset release is at the first rising edge where rst_n=1 and in_valid=1.
- There is no internal state besides the output registers.

## Structure
- Shared package subtractor_pkg holds the default width constant SUB_W_DEFAULT = 4.
- One sub-module, full_subtractor: inputs a, b, bin; outputs d, bout; purely combinational.
- Top level instantiates N full_subtractor cells in a generate loop.
- Top level adds the V/Z logic and the output register bank with asynchronous reset.

## Test plan
- N=4, A=5, B=3, B_in=0, in_valid=1 → next cycle D=2, B_out=0, V=0, Z=0, out_valid=1.
- A=5, B=7, B_in=0 → D=14 (0xE), B_out=1; A=3, B=5, B_in=0 → D=14, B_out=1.
- A=2, B=1, B_in=0 → D=1, B_out=0. A=3, B=3, B_in=0 → D=0, B_out=0, Z=1.
- Borrow-in and wrap: A=0, B=0, B_in=1 → D=15, B_out=1. A=8, B=1, B_in=0 → D=7, V=1, B_out=0.
- Hold and valid: apply a result, then drop in_valid with changing A/B → D is unchanged and out_valid=0.
- Reset and exhaustive: assert rst_n=0 between clock edges → all outputs 0 immediately. Then sweep all 512 combinations of A, B, B_in against a reference model: {B_out, D} equals the (N+1)-bit value of A − B − B_in.

Source files
------------

// File: rtl/subtractor_pkg.sv
// Shared constants for the ripple-borrow subtractor.
package subtractor_pkg;
  localparam int SUB_W_DEFAULT = 4;
endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/subtractor.sv
// N-bit ripple-borrow subtractor D = A - B - B_in with registered result and flags.
module subtractor
  import subtractor_pkg::*;
#(
  parameter int N = SUB_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         B_in,
  input  logic         in_valid,
  output logic [N-1:0] D,
  output logic         B_out,
  output logic         V,
  output logic         Z,
  output logic         out_valid
);
  logic [N:0]   bor;
  logic [N-1:0] diff;
  logic         v_next;
  logic         z_next;

  logic [N-1:0] d_reg;
  logic         b_out_reg;
  logic         v_reg;
  logic         z_reg;
  logic         out_valid_reg;

  assign bor[0] = B_in;

  for (genvar gi = 0; gi < N; gi++) begin : g_cell
    full_subtractor u_cell (
      .a   (A[gi]),
      .b   (B[gi]),
      .bin (bor[gi]),
      .d   (diff[gi]),
      .bout(bor[gi+1])
    );
  end

  // Overflow only possible when operand signs differ and the result sign flips away from A.
  assign v_next = (A[N-1] ^ B[N-1]) & (A[N-1] ^ diff[N-1]);
  assign z_next = (diff == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_reg         <= '0;
      b_out_reg     <= 1'b0;
      v_reg         <= 1'b0;
      z_reg         <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        d_reg     <= diff;
        b_out_reg <= bor[N];
        v_reg     <= v_next;
        z_reg     <= z_next;
      end
    end
  end

  assign D         = d_reg;
  assign B_out     = b_out_reg;
  assign V         = v_reg;
  assign Z         = z_reg;
  assign out_valid = out_valid_reg;
endmodule

// File: tb/tb_subtractor.sv
// Self-checking bench for subtractor (N=4) against an integer-arithmetic reference model.
module tb_subtractor;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         b_in = 1'b0;
  logic         in_valid = 1'b0;
  logic [N-1:0] d;
  logic         b_out;
  logic         v;
  logic         z;
  logic         out_valid;

  int checks = 0;
  int failures = 0;

  // expected registered state
  logic [N-1:0] exp_d = '0;
  logic         exp_bo = 1'b0;
  logic         exp_v = 1'b0;
  logic         exp_z = 1'b0;

  subtractor #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (a),
    .B        (b),
    .B_in     (b_in),
    .in_valid (in_valid),
    .D        (d),
    .B_out    (b_out),
    .V        (v),
    .Z        (z),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, expv);
    end
  endtask

  // Reference: plain unsigned and signed integer arithmetic.
  task automatic model(input int ai, input int bi, input int bini);
    int r, sa, sb, s;
    r  = ai - bi - bini;
    sa = (ai >= 8) ? ai - 16 : ai;
    sb = (bi >= 8) ? bi - 16 : bi;
    s  = sa - sb - bini;
    exp_d  = 4'((r + 32) % 16);
    exp_bo = (r < 0);
    exp_v  = (s < -8) || (s > 7);
    exp_z  = (exp_d == 0);
  endtask

  task automatic check_all(input string tag, input logic exp_ov);
    check({tag, ".D"}, int'(d), int'(exp_d));
    check({tag, ".B_out"}, int'(b_out), int'(exp_bo));
    check({tag, ".V"}, int'(v), int'(exp_v));
    check({tag, ".Z"}, int'(z), int'(exp_z));
    check({tag, ".out_valid"}, int'(out_valid), int'(exp_ov));
  endtask

  task automatic apply(input string tag, input int ai, input int bi, input int bini);
    @(negedge clk);
    a = 4'(ai); b = 4'(bi); b_in = 1'(bini); in_valid = 1'b1;
    @(posedge clk); #1;
    model(ai, bi, bini);
    check_all(tag, 1'b1);
    $display("txn %s A=%0d B=%0d Bin=%0d -> D=%0d Bout=%0d V=%0d Z=%0d", tag, ai, bi, bini, d, b_out, v, z);
  endtask

  initial begin
    // reset state with no clock edge yet
    #2;
    exp_d = '0; exp_bo = 0; exp_v = 0; exp_z = 0;
    check_all("reset0", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed vectors
    apply("t5m3", 5, 3, 0);
    check("t5m3.Dconst", int'(d), 2);
    apply("t5m7", 5, 7, 0);
    check("t5m7.Dconst", int'(d), 14);
    apply("t3m5", 3, 5, 0);
    apply("t2m1", 2, 1, 0);
    apply("t3m3", 3, 3, 0);
    check("t3m3.Zconst", int'(z), 1);
    apply("t0m0b", 0, 0, 1);
    check("t0m0b.Dconst", int'(d), 15);
    apply("t8m1", 8, 1, 0);
    check("t8m1.Vconst", int'(v), 1);
    apply("tFFb", 15, 15, 1);

    // hold: in_valid low with changing operands
    apply("hold_pre", 9, 4, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0; a = 4'($urandom); b = 4'($urandom); b_in = 1'($urandom);
      @(posedge clk); #1;
      check_all("hold", 1'b0);
      $display("txn hold cycle=%0d D=%0d out_valid=%0d", i, d, out_valid);
    end

    // asynchronous reset between edges, with a capture pending
    apply("rst_pre", 7, 2, 0);
    @(negedge clk);
    a = 4'd12; b = 4'd3; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    exp_d = '0; exp_bo = 0; exp_v = 0; exp_z = 0;
    check_all("rst_async", 1'b0);
    @(posedge clk); #1;
    check_all("rst_held", 1'b0);
    $display("txn reset D=%0d out_valid=%0d", d, out_valid);
    @(negedge clk);
    rst_n = 1'b1;

    // exhaustive back-to-back sweep
    for (int bi0 = 0; bi0 < 2; bi0++)
      for (int ai = 0; ai < 16; ai++)
        for (int bi = 0; bi < 16; bi++)
          apply("sweep", ai, bi, bi0);

    // randomized stream with random in_valid gaps
    for (int i = 0; i < 300; i++) begin
      int ra, rb, rc, rv;
      ra = int'($urandom_range(15)); rb = int'($urandom_range(15));
      rc = int'($urandom_range(1));  rv = int'($urandom_range(1));
      @(negedge clk);
      a = 4'(ra); b = 4'(rb); b_in = 1'(rc); in_valid = 1'(rv);
      @(posedge clk); #1;
      if (rv != 0) model(ra, rb, rc);
      check_all("rand", 1'(rv));
      $display("txn rand iv=%0d A=%0d B=%0d Bin=%0d -> D=%0d Bout=%0d V=%0d Z=%0d ov=%0d",
               rv, ra, rb, rc, d, b_out, v, z, out_valid);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
